// File: rtl/frs_message_queue_ctrl_if.sv
// FRS message queue controller bus: message delivery, configuration access,
// and interrupt/status outputs grouped behind one interface.
interface frs_message_queue_ctrl_if;
    logic        frs_msg_valid;
    logic [15:0] frs_msg_func_id;
    logic [3:0]  frs_msg_reason;
    logic        cfg_rd;
    logic        cfg_wr;
    logic [1:0]  cfg_dw_sel;
    logic [31:0] cfg_wdata;
    logic [31:0] hdr_read_data;
    logic [31:0] cfg_rdata;
    logic        cfg_rd_valid;
    logic        irq_req;
    logic [4:0]  irq_msg_num;
    logic        queue_empty;

    // Side that delivers messages and issues config accesses.
    modport master (
        output frs_msg_valid, frs_msg_func_id, frs_msg_reason,
        output cfg_rd, cfg_wr, cfg_dw_sel, cfg_wdata, hdr_read_data,
        input  cfg_rdata, cfg_rd_valid, irq_req, irq_msg_num, queue_empty
    );

    // Controller side.
    modport slave (
        input  frs_msg_valid, frs_msg_func_id, frs_msg_reason,
        input  cfg_rd, cfg_wr, cfg_dw_sel, cfg_wdata, hdr_read_data,
        output cfg_rdata, cfg_rd_valid, irq_req, irq_msg_num, queue_empty
    );
endinterface

// File: rtl/frs_message_queue_ctrl.sv
// FRS Queueing capability controller: bounded FIFO of received FRS messages,
// capability/control/queue config dwords, RW1C status and interrupt request.
module frs_message_queue_ctrl #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [4:0]  INT_MSG_NUM = 5'd0
) (
    input  logic                        clk,
    input  logic                        rst,
    frs_message_queue_ctrl_if.slave     bus
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [11:0]      DEPTH_FIELD = 12'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        DW_HDR   = 2'd0,
        DW_CAP   = 2'd1,
        DW_CTRL  = 2'd2,
        DW_QUEUE = 2'd3
    } dw_sel_e;

    // Entry layout: {reason[3:0], func_id[15:0]}
    logic [19:0]      mem_q [QUEUE_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             msg_received_q, msg_received_d;
    logic             msg_overflow_q, msg_overflow_d;
    logic             int_enable_q, int_enable_d;
    logic             irq_ev_q, irq_ev_d;
    logic             irq_req_q, irq_req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rd_valid_q, rd_valid_d;
    logic             queue_empty_q, queue_empty_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             deq_req;
    logic             ctrl_wr;
    logic             do_deq;
    logic             do_enq;
    logic             overflow_evt;
    logic             mem_we;
    logic [19:0]      mem_wdata;
    logic [19:0]      head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO bookkeeping, RW1C status and interrupt edge detection.
    // Dequeue is resolved before enqueue so a full FIFO can accept a message
    // in the same cycle it is popped.
    always_comb begin
        fifo_empty     = (count_q == '0);
        fifo_full      = (count_q == DEPTH_CNT);
        deq_req        = bus.cfg_wr && (bus.cfg_dw_sel == DW_QUEUE);
        ctrl_wr        = bus.cfg_wr && (bus.cfg_dw_sel == DW_CTRL);
        do_deq         = deq_req && !fifo_empty;
        do_enq         = bus.frs_msg_valid && (!fifo_full || do_deq);
        overflow_evt   = bus.frs_msg_valid && fifo_full && !do_deq;

        mem_we         = do_enq && !rst;
        mem_wdata      = {bus.frs_msg_reason, bus.frs_msg_func_id};

        head_d         = do_deq ? ptr_inc(head_q) : head_q;
        tail_d         = do_enq ? ptr_inc(tail_q) : tail_q;
        count_d        = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        queue_empty_d  = (count_d == '0);

        // Hardware set takes priority over a simultaneous software clear.
        msg_received_d = (msg_received_q & ~(ctrl_wr & bus.cfg_wdata[0]))
                         | bus.frs_msg_valid;
        msg_overflow_d = (msg_overflow_q & ~(ctrl_wr & bus.cfg_wdata[1]))
                         | overflow_evt;
        int_enable_d   = ctrl_wr ? bus.cfg_wdata[16] : int_enable_q;

        irq_ev_d       = msg_received_d & int_enable_d;
        irq_req_d      = irq_ev_d & ~irq_ev_q;
    end

    // Config read mux; samples state before this cycle's updates.
    always_comb begin
        head_entry = fifo_empty ? '0 : mem_q[head_q];
        rd_valid_d = bus.cfg_rd;
        rdata_d    = rdata_q;
        if (bus.cfg_rd) begin
            unique case (bus.cfg_dw_sel)
                DW_HDR:   rdata_d = bus.hdr_read_data;
                DW_CAP:   rdata_d = {11'b0, INT_MSG_NUM, 4'b0, DEPTH_FIELD};
                DW_CTRL:  rdata_d = {15'b0, int_enable_q, 14'b0,
                                     msg_overflow_q, msg_received_q};
                DW_QUEUE: rdata_d = {12'b0, head_entry};
                default:  rdata_d = '0;
            endcase
        end
    end

    // FIFO storage; not reset, validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[tail_q] <= mem_wdata;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            msg_received_q <= 1'b0;
            msg_overflow_q <= 1'b0;
            int_enable_q   <= 1'b0;
            irq_ev_q       <= 1'b0;
            irq_req_q      <= 1'b0;
            rdata_q        <= '0;
            rd_valid_q     <= 1'b0;
            queue_empty_q  <= 1'b1;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            msg_received_q <= msg_received_d;
            msg_overflow_q <= msg_overflow_d;
            int_enable_q   <= int_enable_d;
            irq_ev_q       <= irq_ev_d;
            irq_req_q      <= irq_req_d;
            rdata_q        <= rdata_d;
            rd_valid_q     <= rd_valid_d;
            queue_empty_q  <= queue_empty_d;
        end
    end

    assign bus.cfg_rdata    = rdata_q;
    assign bus.cfg_rd_valid = rd_valid_q;
    assign bus.irq_req      = irq_req_q;
    assign bus.irq_msg_num  = INT_MSG_NUM;
    assign bus.queue_empty  = queue_empty_q;

endmodule

// File: tb/tb_frs_message_queue_ctrl.sv
// Self-checking bench for frs_message_queue_ctrl (QUEUE_DEPTH=4, INT_MSG_NUM=3).
module tb_frs_message_queue_ctrl;

    logic clk;
    logic rst;

    frs_message_queue_ctrl_if bus();

    frs_message_queue_ctrl #(
        .QUEUE_DEPTH(4),
        .INT_MSG_NUM(5'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [15:0] id;
        logic [3:0]  rsn;
        logic        rd;
        logic        wr;
        logic [1:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        exp_empty;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } rd_exp_t;

    vec_t        tbl [19];
    rd_exp_t     exp_q [$];
    logic [31:0] last_exp;
    logic [31:0] hdr_val;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, queue any read expectation, sample #1 after the edge.
    task automatic cyc(input logic r, input logic v, input logic [15:0] id, input logic [3:0] rsn,
                       input logic rd, input logic wr, input logic [1:0] sel, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_irq, input logic exp_empty);
        rd_exp_t e;
        rst                 = r;
        bus.frs_msg_valid   = v;
        bus.frs_msg_func_id = id;
        bus.frs_msg_reason  = rsn;
        bus.cfg_rd          = rd;
        bus.cfg_wr          = wr;
        bus.cfg_dw_sel      = sel;
        bus.cfg_wdata       = wd;
        bus.hdr_read_data   = hdr_val;
        if (rd && !r) begin
            e.sel  = sel;
            e.data = exp_rd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            last_exp = 32'h0;
        end
        chk("irq_req", {31'b0, bus.irq_req}, {31'b0, exp_irq});
        chk("queue_empty", {31'b0, bus.queue_empty}, {31'b0, exp_empty});
        if (bus.cfg_rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rdata_dw%0d", e.sel), bus.cfg_rdata, e.data);
                last_exp = e.data;
            end
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_rd_valid", 32'h0, 32'h1);
            end
            chk("rdata_hold", bus.cfg_rdata, last_exp);
        end
    endtask

    task automatic enq(input logic [15:0] id, input logic [3:0] rsn, input logic exp_empty);
        cyc(1'b0, 1'b1, id, rsn, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, exp_empty);
    endtask

    task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input logic exp_empty);
        cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, sel, 32'h0, exp, 1'b0, exp_empty);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] wd, input logic exp_empty);
        cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, sel, wd, 32'h0, 1'b0, exp_empty);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = 32'h0;
        hdr_val  = 32'hBEEF_0001;
        rst                 = 1'b1;
        bus.frs_msg_valid   = 1'b0;
        bus.frs_msg_func_id = 16'h0;
        bus.frs_msg_reason  = 4'h0;
        bus.cfg_rd          = 1'b0;
        bus.cfg_wr          = 1'b0;
        bus.cfg_dw_sel      = 2'd0;
        bus.cfg_wdata       = 32'h0;
        bus.hdr_read_data   = hdr_val;

        //          r     v     id        rsn   rd    wr    sel   wdata          exp_rd         irq   empty
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0003_0004, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 32'hBEEF_0001, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0003_0004, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0003_0004, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 2'd2, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 16'h0108, 4'h2, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0001_0001, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0002_0108, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 2'd3, 32'h0000_0000, 32'h0002_0108, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 2'd2, 32'h0001_0001, 32'h0000_0000, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 16'h0042, 4'hF, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 2'd2, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0001_0001, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].id, tbl[i].rsn, tbl[i].rd, tbl[i].wr,
                tbl[i].sel, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_irq, tbl[i].exp_empty);
        end
        chk("irq_msg_num", {27'b0, bus.irq_msg_num}, 32'd3);

        // Overflow: five messages into a depth-4 queue, id 5 is dropped.
        wr(2'd2, 32'h0000_0003, 1'b1);
        for (int k = 1; k <= 5; k++) enq(16'(k), 4'h1, 1'b0);
        rd(2'd2, 32'h0000_0003, 1'b0);
        rd(2'd3, 32'h0001_0001, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            wr(2'd3, 32'h0, 1'b0);
            rd(2'd3, {12'b0, 4'h1, 16'(k)}, 1'b0);
        end
        wr(2'd3, 32'h0, 1'b1);
        rd(2'd3, 32'h0, 1'b1);
        wr(2'd3, 32'h0, 1'b1);

        // Full queue: enqueue and dequeue in the same cycle, no overflow.
        wr(2'd2, 32'h0000_0003, 1'b1);
        for (int k = 1; k <= 4; k++) enq(16'(16'h10 + k), 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 16'h0015, 4'h3, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        rd(2'd2, 32'h0000_0001, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1, 2'd3, 32'h0,
                {12'b0, 4'h3, 16'(16'h10 + k)}, 1'b0, (k == 5));
        end

        // RW1C clear racing a hardware set.
        for (int k = 1; k <= 5; k++) enq(16'(16'h20 + k), 4'h4, 1'b0);
        rd(2'd2, 32'h0000_0003, 1'b0);
        wr(2'd3, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0026, 4'h4, 1'b0, 1'b1, 2'd2, 32'h0000_0003, 32'h0, 1'b0, 1'b0);
        rd(2'd2, 32'h0000_0001, 1'b0);
        wr(2'd2, 32'h0000_0001, 1'b0);
        rd(2'd2, 32'h0000_0000, 1'b0);
        rd(2'd3, 32'h0004_0022, 1'b0);

        // Header passthrough follows the live input.
        hdr_val = 32'h5A5A_C3C3;
        rd(2'd0, 32'h5A5A_C3C3, 1'b0);

        // Reset mid-operation with 3 entries queued and interrupts enabled.
        wr(2'd3, 32'h0, 1'b0);
        wr(2'd2, 32'h0001_0000, 1'b0);
        cyc(1'b1, 1'b1, 16'h0077, 4'h7, 1'b0, 1'b1, 2'd2, 32'h0001_0000, 32'h0, 1'b0, 1'b1);
        rd(2'd2, 32'h0000_0000, 1'b1);
        rd(2'd3, 32'h0000_0000, 1'b1);
        rd(2'd1, 32'h0003_0004, 1'b1);
        enq(16'h0007, 4'h1, 1'b0);
        rd(2'd2, 32'h0000_0001, 1'b0);
        rd(2'd3, 32'h0001_0007, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frs_message_queue_ctrl.md
# frs_message_queue_ctrl

Controller behind the FRS Queueing Extended Capability of a Root Port / RCEC. It captures incoming FRS Messages into a bounded FIFO and serves the capability's configuration dwords 1–3: Capability, Control/Status and Message Queue. It also maintains the RW1C status bits and raises an interrupt request toward the MSI/MSI-X logic. Dword 0, the capability header, is produced by the existing header block and passed through by this controller.

## Interface
- QUEUE_DEPTH, 4, implemented FIFO depth; legal range 1..4095; reported in the Capability register [11:0].
- INT_MSG_NUM, 5'd0, FRS Interrupt Message Number; reported in the Capability register [20:16].
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- frs_msg_valid  in  1  one FRS Message delivered this cycle; never back-pressured.
- frs_msg_func_id  in  16  Function ID of the message.
- frs_msg_reason  in  4  FRS Reason of the message.
- cfg_rd  in  1  config read strobe.
- cfg_wr  in  1  config write strobe, full dword.
- cfg_dw_sel  in  2  dword within the capability: 0 header, 1 capability, 2 control/status, 3 queue.
- cfg_wdata  in  32  write data.
- hdr_read_data  in  32  header dword from the header block.
- cfg_rdata  out  32  read data.
- cfg_rd_valid  out  1  read data valid.
- irq_req  out  1  one-cycle interrupt request pulse.
- irq_msg_num  out  5  constant INT_MSG_NUM.
- queue_empty  out  1  FIFO holds no entries.

## Operation
- FIFO stores {reason[3:0], func_id[15:0]}, QUEUE_DEPTH entries. Pointers wrap modulo QUEUE_DEPTH. Count width is $clog2(QUEUE_DEPTH+1).
- Enqueue: frs_msg_valid with the FIFO not full writes the entry at the tail and sets msg_received.
- Enqueue while full: the message is discarded. msg_overflow and msg_received are both set. Existing contents are unchanged.
- Dequeue: cfg_wr to dword 3 with any data removes the head entry. On an empty FIFO this is a no-op.
- Same cycle, enqueue and dequeue: the dequeue is applied first.
  - If the FIFO is full, the incoming message is accepted, count is unchanged and there is no overflow.
  - If the FIFO is empty, the dequeue is a no-op and the enqueue proceeds (count becomes 1).
- Capability dword reads {11'b0, INT_MSG_NUM, 4'b0, QUEUE_DEPTH[11:0]}. Writes to it are ignored.
- Control/Status dword:
  - bit0 msg_received, RW1C.
  - bit1 msg_overflow, RW1C.
  - bit16 int_enable, RW.
  - All other bits read 0.
  - A hardware set in the same cycle as a software write-1-clear: the set wins.
- Queue dword reads {12'b0, head_reason, head_func_id}. When the FIFO is empty it reads 32'h0.
- Header dword returns hdr_read_data sampled in the cycle of cfg_rd. Writes to it are ignored.
- Interrupt: irq_ev = msg_received & int_enable. irq_req pulses for one cycle on each 0→1 transition of irq_ev (registered), whether the cause is a message or software setting int_enable.
- Simultaneous cfg_rd and cfg_wr: the read returns pre-write state.

## Timing
- Reset values: FIFO empty, all pointers 0, msg_received 0, msg_overflow 0, int_enable 0, cfg_rdata 0, cfg_rd_valid 0, irq_req 0, queue_empty 1.
- Reset asserted mid-operation flushes the FIFO and clears all status on the next edge. Inputs in that cycle are ignored.
- Read latency is 1 cycle:
  - cfg_rd in cycle N gives cfg_rd_valid=1 and cfg_rdata in N+1.
  - The data reflects state before any update in cycle N.
  - cfg_rdata holds its value when cfg_rd_valid=0.
- An enqueue in cycle N is visible to a read issued in N+1. msg_received is 1 from N+1.
- A dequeue write in cycle N means a read issued in N+1 returns the new head.
- irq_req is asserted in cycle N+1 when irq_ev rises as a result of cycle N's update. Maximum one pulse per rising edge of irq_ev.
- queue_empty is registered and updates with the count.

## Test plan
- Reset, then read dwords 1/2/3 with QUEUE_DEPTH=4, INT_MSG_NUM=3 → 32'h0003_0004, 32'h0, 32'h0; queue_empty=1, irq_req=0.
- Write dword2=32'h0001_0000, enqueue {reason 4'h2, id 16'h0108} → single irq_req pulse. Dword2 reads 32'h0001_0001. Dword3 reads 32'h0002_0108.
- Enqueue 5 messages (ids 1..5) at depth 4 → overflow bit set. Dword3 reads id 1, then after each dequeue write reads 2, 3, 4, then 0. Id 5 is never seen.
- With the FIFO full, enqueue and dequeue in the same cycle → count stays 4, overflow stays 0, and the new entry appears last in order.
- Write 32'h3 to dword2 in the same cycle as an enqueue → msg_received remains 1 and msg_overflow clears. A later write of 32'h1 with no enqueue clears msg_received.
- Assert rst with 3 entries queued and int_enable=1 → next cycle queue_empty=1, dword2 reads 0, dword3 reads 0, and no irq_req.
